// File: rtl/div_sequencer.sv
// Multi-cycle RV64M divide/remainder sequencer: restoring division, one quotient
// bit per cycle, borrowing the shared ALU as an unsigned subtractor/comparator.
module div_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            start_in,
  input  logic            flush_in,
  input  logic [XLEN-1:0] dividend_in,
  input  logic [XLEN-1:0] divisor_in,
  input  logic            signed_in,
  input  logic            rem_sel_in,
  input  logic            word_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] alu_value1_out,
  output logic [XLEN-1:0] alu_value2_out,
  output logic [2:0]      alu_op_signal_out,
  output logic            add_sub_srl_sra_signal_out,
  output logic [2:0]      width_data_signal_out,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic            alu_carry_in
);

  localparam logic [2:0] ALU_OP_ADD_SUB  = 3'b000;
  localparam logic [2:0] MEM_WIDTH_DWORD = 3'b011;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] q_q, q_d, r_q, r_d, bmag_q, bmag_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            signed_q, signed_d, rem_q, rem_d, word_q, word_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;

  logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, min_val, r_prime;
  logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;
  logic            sa, sb, div0, ovf, take;

  always_comb begin
    a_eff = a_q;
    b_eff = b_q;
    if (word_q) begin
      a_eff = signed_q ? {{32{a_q[31]}}, a_q[31:0]} : {32'b0, a_q[31:0]};
      b_eff = signed_q ? {{32{b_q[31]}}, b_q[31:0]} : {32'b0, b_q[31:0]};
    end
    sa      = signed_q & a_eff[XLEN-1];
    sb      = signed_q & b_eff[XLEN-1];
    a_mag   = sa ? -a_eff : a_eff;
    b_mag   = sb ? -b_eff : b_eff;
    min_val = word_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div0    = (b_eff == '0);
    ovf     = signed_q & (a_eff == min_val) & (b_eff == '1);
    // The R msb covers divisors >= 2^63, where R' overflows 64 bits.
    r_prime = {r_q[XLEN-2:0], q_q[XLEN-1]};
    take    = r_q[XLEN-1] | ~alu_carry_in;
    q_fix   = qneg_q ? -q_q : q_q;
    r_fix   = rneg_q ? -r_q : r_q;
    sel_fix = rem_q ? r_fix : q_fix;
    fix_res = word_q ? {{32{sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    r_d      = r_q;
    bmag_d   = bmag_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    rem_d    = rem_q;
    word_d   = word_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_in) begin
          a_d      = dividend_in;
          b_d      = divisor_in;
          signed_d = signed_in;
          rem_d    = rem_sel_in;
          word_d   = word_in;
          state_d  = S_PREP;
        end
        S_PREP: begin
          bmag_d = b_mag;
          // Special cases skip ITER; FIX still does the select and W extension.
          if (div0 | ovf) begin
            q_d     = div0 ? '1 : a_eff;
            r_d     = div0 ? a_eff : '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIX;
          end else begin
            q_d     = word_q ? (a_mag << 32) : a_mag;
            r_d     = '0;
            qneg_d  = sa ^ sb;
            rneg_d  = sa;
            cnt_d   = word_q ? 6'd31 : 6'd63;
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          r_d   = take ? alu_result_in : r_prime;
          q_d   = {q_q[XLEN-2:0], take};
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd0) state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      r_q      <= '0;
      bmag_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      signed_q <= 1'b0;
      rem_q    <= 1'b0;
      word_q   <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      r_q      <= r_d;
      bmag_q   <= bmag_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      signed_q <= signed_d;
      rem_q    <= rem_d;
      word_q   <= word_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  always_comb begin
    busy_out                   = (state_q != S_IDLE);
    done_out                   = (state_q == S_DONE);
    result_out                 = result_q;
    alu_value1_out             = (state_q == S_ITER) ? r_prime : '0;
    alu_value2_out             = busy_out ? bmag_q : '0;
    alu_op_signal_out          = busy_out ? ALU_OP_ADD_SUB : 3'b000;
    add_sub_srl_sra_signal_out = busy_out;
    width_data_signal_out      = busy_out ? (MEM_WIDTH_DWORD | 3'b100) : 3'b000;
  end

endmodule
